// File: rtl/if_id_skid_register_if.sv
// Valid/ready instruction stream carrying one fetched instruction and its PC.
// The producer drives valid/instruction/pc through master; the consumer drives ready through slave.
interface if_id_skid_register_if #(
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH    = 32
);
  logic                   valid;
  logic                   ready;
  logic [INSTR_WIDTH-1:0] instruction;
  logic [PC_WIDTH-1:0]    pc;

  modport master (output valid, output instruction, output pc, input ready);
  modport slave  (input valid, input instruction, input pc, output ready);
endinterface

// File: rtl/if_id_skid_register.sv
// IF->ID pipeline register with a two-entry skid buffer, so fetch never sees a combinational ready from decode.
// Optional macro IF_ID_BUBBLE_NOP_EN makes empty cycles present ADDI x0,x0,0 instead of zero.
module if_id_skid_register #(
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  if_id_skid_register_if.slave   in_bus,
  if_id_skid_register_if.master  out_bus
);

`ifdef IF_ID_BUBBLE_NOP_EN
  localparam logic [INSTR_WIDTH-1:0] BUBBLE = INSTR_WIDTH'(32'h0000_0013);
`else
  localparam logic [INSTR_WIDTH-1:0] BUBBLE = INSTR_WIDTH'(32'h0000_0000);
`endif

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [INSTR_WIDTH-1:0] main_instr;
  logic [PC_WIDTH-1:0]    main_pc;
  logic [INSTR_WIDTH-1:0] skid_instr;
  logic [PC_WIDTH-1:0]    skid_pc;
  logic                   in_ready_int;
  logic                   out_valid_int;
  logic                   in_fire;
  logic                   out_fire;
  logic                   load_main_in;
  logic                   load_main_skid;
  logic                   load_skid_in;

  // Both handshake outputs come straight from the state register, so no
  // combinational path exists between decode's ready and fetch's ready.
  assign in_ready_int  = (state != FULL);
  assign out_valid_int = (state != EMPTY);
  assign in_fire       = in_bus.valid && in_ready_int;
  assign out_fire      = out_valid_int && out_bus.ready;

  assign in_bus.ready        = in_ready_int;
  assign out_bus.valid       = out_valid_int;
  assign out_bus.instruction = out_valid_int ? main_instr : BUBBLE;
  assign out_bus.pc          = out_valid_int ? main_pc : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Flush overrides the handshake entirely: nothing loads and the buffer empties.
  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            load_main_in = 1'b1;
            state_next   = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            load_skid_in = 1'b1;
            state_next   = FULL;
          end else if (out_fire) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            load_main_skid = 1'b1;
            state_next     = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_instr <= '0;
      main_pc    <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      if (load_main_in) begin
        main_instr <= in_bus.instruction;
        main_pc    <= in_bus.pc;
      end else if (load_main_skid) begin
        main_instr <= skid_instr;
        main_pc    <= skid_pc;
      end
      if (load_skid_in) begin
        skid_instr <= in_bus.instruction;
        skid_pc    <= in_bus.pc;
      end
    end
  end

endmodule

// File: tb/tb_if_id_skid_register.sv
// Scenario bench for if_id_skid_register: accepted beats go into a queue and are popped
// when decode takes them. Inputs are driven and outputs sampled on the falling edge.
module tb_if_id_skid_register;

`ifdef IF_ID_BUBBLE_NOP_EN
  localparam logic [31:0] BUBBLE = 32'h0000_0013;
`else
  localparam logic [31:0] BUBBLE = 32'h0000_0000;
`endif

  logic clk;
  logic reset;
  logic flush;
  int   vectors;
  int   miscompares;
  logic [63:0] sb[$];

  if_id_skid_register_if #(.INSTR_WIDTH(32), .PC_WIDTH(32)) in_bus ();
  if_id_skid_register_if #(.INSTR_WIDTH(32), .PC_WIDTH(32)) out_bus ();

  if_id_skid_register #(.INSTR_WIDTH(32), .PC_WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .in_bus  (in_bus.slave),
    .out_bus (out_bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_bus.valid       = v;
    in_bus.instruction = instr;
    in_bus.pc          = pc;
  endtask

  // Leaves the DUT in FULL with a then b held and decode stalled.
  task automatic fill_full(input logic [31:0] a, input logic [31:0] b);
    out_bus.ready = 1'b0;
    drive(1'b1, a, 32'h40);
    sb.push_back({32'h40, a});
    tick();
    drive(1'b1, b, 32'h44);
    sb.push_back({32'h44, b});
    tick();
    drive(1'b0, '0, '0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    out_bus.ready = 1'b0;
    drive(1'b0, '0, '0);
    tick();
    tick();
    reset = 1'b0;
    vectors++;
    if (in_bus.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_bus.ready); end
    vectors++;
    if (out_bus.valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_bus.valid); end
    vectors++;
    if (out_bus.instruction !== BUBBLE) begin miscompares++; $display("[TB] FAIL reset_instr: got %h expected %h", out_bus.instruction, BUBBLE); end
    vectors++;
    if (out_bus.pc !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_pc: got %h expected 0", out_bus.pc); end
  endtask

  task automatic test_streaming();
    logic [31:0] instrs [2];
    logic [63:0] exp;
    instrs[0] = 32'h0050_0093;
    instrs[1] = 32'h00A0_0113;
    out_bus.ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, instrs[i], 32'(i * 4));
      vectors++;
      if (in_bus.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL stream_in_ready: got %b expected 1", in_bus.ready); end
      sb.push_back({32'(i * 4), instrs[i]});
      tick();
      exp = sb.pop_front();
      vectors++;
      if (out_bus.valid !== 1'b1 || {out_bus.pc, out_bus.instruction} !== exp) begin
        miscompares++;
        $display("[TB] FAIL stream_out: got v=%b %h expected v=1 %h", out_bus.valid, {out_bus.pc, out_bus.instruction}, exp);
      end
    end
    drive(1'b0, '0, '0);
    tick();
    vectors++;
    if (out_bus.valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_drain: got %b expected 0", out_bus.valid); end
  endtask

  task automatic test_stall_fill();
    logic [63:0] exp;
    bit pushed;
    int seen;
    fill_full(32'hA000_000A, 32'hB000_000B);
    drive(1'b1, 32'hC000_000C, 32'h48);
    vectors++;
    if (in_bus.ready !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_in_ready: got %b expected 0", in_bus.ready); end
    tick();
    vectors++;
    if (out_bus.instruction !== 32'hA000_000A || out_bus.valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stall_hold: got v=%b %h expected v=1 a000000a", out_bus.valid, out_bus.instruction);
    end
    out_bus.ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8 && (sb.size() > 0 || in_bus.valid); i++) begin
      pushed = 1'b0;
      if (out_bus.valid && out_bus.ready) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        seen++;
        vectors++;
        if ({out_bus.pc, out_bus.instruction} !== exp) begin
          miscompares++;
          $display("[TB] FAIL stall_release_order: got %h expected %h", {out_bus.pc, out_bus.instruction}, exp);
        end
      end
      if (in_bus.valid && in_bus.ready) begin
        sb.push_back({in_bus.pc, in_bus.instruction});
        pushed = 1'b1;
      end
      tick();
      if (pushed) drive(1'b0, '0, '0);
    end
    vectors++;
    if (seen !== 3 || out_bus.valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_release_count: got %0d v=%b expected 3 v=0", seen, out_bus.valid);
    end
    sb.delete();
  endtask

  task automatic test_flush_full();
    fill_full(32'h1111_1111, 32'h2222_2222);
    drive(1'b1, 32'h3333_3333, 32'h48);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    sb.delete();
    vectors++;
    if (out_bus.valid !== 1'b0 || in_bus.ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_state: got v=%b r=%b expected v=0 r=1", out_bus.valid, in_bus.ready);
    end
    vectors++;
    if (out_bus.instruction !== BUBBLE || out_bus.pc !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL flush_bubble: got %h/%h expected %h/0", out_bus.instruction, out_bus.pc, BUBBLE);
    end
    out_bus.ready = 1'b1;
    tick();
    vectors++;
    if (out_bus.valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_nothing_left: got %b expected 0", out_bus.valid); end
  endtask

  task automatic test_simultaneous();
    logic [63:0] exp;
    out_bus.ready = 1'b0;
    drive(1'b1, 32'hAAAA_0001, 32'h80);
    sb.push_back({32'h80, 32'hAAAA_0001});
    tick();
    out_bus.ready = 1'b1;
    drive(1'b1, 32'hBBBB_0002, 32'h84);
    exp = sb.pop_front();
    vectors++;
    if ({out_bus.pc, out_bus.instruction} !== exp) begin
      miscompares++;
      $display("[TB] FAIL simul_first: got %h expected %h", {out_bus.pc, out_bus.instruction}, exp);
    end
    sb.push_back({32'h84, 32'hBBBB_0002});
    tick();
    drive(1'b0, '0, '0);
    exp = sb.pop_front();
    vectors++;
    if ({out_bus.pc, out_bus.instruction} !== exp || in_bus.ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL simul_second: got %h r=%b expected %h r=1", {out_bus.pc, out_bus.instruction}, in_bus.ready, exp);
    end
    tick();
    vectors++;
    if (out_bus.valid !== 1'b0) begin miscompares++; $display("[TB] FAIL simul_skid_unused: got %b expected 0", out_bus.valid); end
  endtask

  task automatic test_reset_mid_stall();
    fill_full(32'h5555_5555, 32'h6666_6666);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    vectors++;
    if (in_bus.ready !== 1'b1 || out_bus.valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_state: got r=%b v=%b expected r=1 v=0", in_bus.ready, out_bus.valid);
    end
    out_bus.ready = 1'b1;
    drive(1'b1, 32'h0000_0033, 32'h200);
    tick();
    drive(1'b0, '0, '0);
    vectors++;
    if (out_bus.valid !== 1'b1 || out_bus.instruction !== 32'h0000_0033 || out_bus.pc !== 32'h200) begin
      miscompares++;
      $display("[TB] FAIL midreset_push: got v=%b %h@%h expected v=1 00000033@00000200", out_bus.valid, out_bus.instruction, out_bus.pc);
    end
    tick();
    vectors++;
    if (out_bus.valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_drain: got %b expected 0", out_bus.valid); end
  endtask

  // Random handshakes on both sides; the queue depth doubles as an occupancy model.
  task automatic test_back_to_back();
    logic [63:0] exp;
    for (int i = 0; i < 300; i++) begin
      out_bus.ready = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 1)), $urandom, 32'(i * 4));
      vectors++;
      if (out_bus.valid !== (sb.size() != 0) || in_bus.ready !== (sb.size() < 2)) begin
        miscompares++;
        $display("[TB] FAIL b2b_occupancy: got v=%b r=%b expected depth %0d", out_bus.valid, in_bus.ready, sb.size());
      end
      if (out_bus.valid && out_bus.ready) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        vectors++;
        if ({out_bus.pc, out_bus.instruction} !== exp) begin
          miscompares++;
          $display("[TB] FAIL b2b_data: got %h expected %h", {out_bus.pc, out_bus.instruction}, exp);
        end
      end
      if (in_bus.valid && in_bus.ready) sb.push_back({in_bus.pc, in_bus.instruction});
      tick();
    end
    drive(1'b0, '0, '0);
    out_bus.ready = 1'b1;
    for (int i = 0; i < 4 && sb.size() > 0; i++) begin
      exp = sb.pop_front();
      vectors++;
      if (out_bus.valid !== 1'b1 || {out_bus.pc, out_bus.instruction} !== exp) begin
        miscompares++;
        $display("[TB] FAIL b2b_drain: got v=%b %h expected %h", out_bus.valid, {out_bus.pc, out_bus.instruction}, exp);
      end
      tick();
    end
    vectors++;
    if (sb.size() != 0 || out_bus.valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_empty: got depth %0d v=%b expected 0 v=0", sb.size(), out_bus.valid);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    flush = 1'b0;
    out_bus.ready = 1'b0;
    drive(1'b0, '0, '0);
    test_reset();
    test_streaming();
    test_stall_fill();
    test_flush_full();
    test_simultaneous();
    test_reset_mid_stall();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
